// File: rtl/rover_drive_controller.sv
// Rover drive-word consumer: synchronizes and debounces the command word, ramps
// left/right duties toward decoded targets and drives H-bridge PWM/direction lines.
module rover_drive_controller #(
    parameter int PWM_PERIOD      = 1000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int RAMP_DIV        = 1000,
    parameter int RAMP_STEP       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic       end_reset,
    output logic       PWM_L,
    output logic       PWM_R,
    output logic       DIR_L,
    output logic       DIR_R,
    output logic [1:0] mode,
    output logic       moving
);
    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam logic [DW-1:0] PCNT_MAX = DW'(PWM_PERIOD - 1);
    localparam logic [DW-1:0] STEP     = DW'(RAMP_STEP);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_FULL  = CW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] RDIV_MAX = RW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        BRAKE = 2'b10,
        HALT  = 2'b11
    } fsm_t;

    function automatic logic [DW-1:0] speed_duty(input logic [2:0] spd);
        int unsigned full;
        full = (32'(spd) * 32'(PWM_PERIOD)) >> 3;
        return DW'(full);
    endfunction

    // One ramp step toward the target, clamped so it lands exactly on it.
    function automatic logic [DW-1:0] ramp_to(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
        if (cur < tgt) return (tgt - cur > STEP) ? cur + STEP : tgt;
        if (cur > tgt) return (cur - tgt > STEP) ? cur - STEP : tgt;
        return cur;
    endfunction

    logic [6:0]    state_p0, state_p1, word_p2, cmd;
    logic          halt_p0, halt_p1;
    logic [CW-1:0] stable_cnt;
    logic          unused_bit;

    assign unused_bit = state[7];

    // Stage p0/p1: two-flop synchronizers; p2: stability tracking and command latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0   <= '0;
            state_p1   <= '0;
            halt_p0    <= 1'b0;
            halt_p1    <= 1'b0;
            word_p2    <= '0;
            stable_cnt <= '0;
            cmd        <= '0;
        end else begin
            state_p0 <= state[6:0];
            state_p1 <= state_p0;
            halt_p0  <= end_reset;
            halt_p1  <= halt_p0;
            if (state_p1 != word_p2) begin
                word_p2    <= state_p1;
                stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
                stable_cnt <= DB_FULL;
                cmd        <= word_p2;
            end else if (stable_cnt != DB_FULL) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    logic [DW-1:0] tgt_full, tgt_l, tgt_r;
    logic [1:0]    want_pat, dir_pat;   // {left, right}, 1 = forward

    always_comb begin
        tgt_full = speed_duty(cmd[6:4]);
        tgt_l    = tgt_full;
        tgt_r    = tgt_full;
        want_pat = dir_pat;
        case (cmd[1:0])
            2'b00: begin
                tgt_l = '0;
                tgt_r = '0;
            end
            2'b01, 2'b10: begin
                want_pat = cmd[0] ? 2'b11 : 2'b00;
                if (cmd[3:2] == 2'b01)      tgt_l = tgt_full >> 1;
                else if (cmd[3:2] == 2'b10) tgt_r = tgt_full >> 1;
            end
            default: want_pat = 2'b01;
        endcase
    end

    fsm_t          fsm;
    logic [DW-1:0] duty_l, duty_r, lat_l, lat_r, pcnt;
    logic [RW-1:0] rdiv;
    logic          ramp_tick, wrap, all_zero, has_tgt;

    assign ramp_tick = (rdiv == RDIV_MAX);
    assign wrap      = (pcnt == PCNT_MAX);
    assign has_tgt   = (tgt_l != '0) || (tgt_r != '0);
    // Direction may only change once the PWM-latched duties are zero as well.
    assign all_zero  = (duty_l == '0) && (duty_r == '0) && (lat_l == '0) && (lat_r == '0);

    // Stage p3: mode FSM, duty ramp, PWM generation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm     <= IDLE;
            dir_pat <= 2'b11;
            duty_l  <= '0;
            duty_r  <= '0;
            lat_l   <= '0;
            lat_r   <= '0;
            pcnt    <= '0;
            rdiv    <= '0;
            PWM_L   <= 1'b0;
            PWM_R   <= 1'b0;
            moving  <= 1'b0;
        end else begin
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            rdiv <= ramp_tick ? '0 : rdiv + 1'b1;
            if (halt_p1) begin
                fsm    <= HALT;
                duty_l <= '0;
                duty_r <= '0;
                lat_l  <= '0;
                lat_r  <= '0;
                PWM_L  <= 1'b0;
                PWM_R  <= 1'b0;
                moving <= 1'b0;
            end else begin
                PWM_L  <= (pcnt < lat_l);
                PWM_R  <= (pcnt < lat_r);
                moving <= (duty_l != '0) || (duty_r != '0);
                if (wrap) begin
                    lat_l <= duty_l;
                    lat_r <= duty_r;
                end
                case (fsm)
                    IDLE: begin
                        if (has_tgt) begin
                            fsm     <= RUN;
                            dir_pat <= want_pat;
                        end
                    end
                    RUN: begin
                        if (want_pat != dir_pat) begin
                            if (all_zero) dir_pat <= want_pat;
                            else          fsm     <= BRAKE;
                        end else begin
                            if (all_zero && !has_tgt) fsm <= IDLE;
                            if (ramp_tick) begin
                                duty_l <= ramp_to(duty_l, tgt_l);
                                duty_r <= ramp_to(duty_r, tgt_r);
                            end
                        end
                    end
                    BRAKE: begin
                        if (all_zero) begin
                            dir_pat <= want_pat;
                            fsm     <= has_tgt ? RUN : IDLE;
                        end else if (ramp_tick) begin
                            duty_l <= ramp_to(duty_l, '0);
                            duty_r <= ramp_to(duty_r, '0);
                        end
                    end
                    default: begin
                        if (cmd[1:0] == 2'b00) fsm <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mode  = fsm;
    assign DIR_L = dir_pat[1];
    assign DIR_R = dir_pat[0];

endmodule

// File: doc/rover_drive_controller.md
# rover_drive_controller

Command consumer for the delivery rover's 8-bit drive word. It synchronizes and debounces the switch-derived `state` word and decodes it into direction, turn and speed. It ramps motor duty cycles toward the target and generates left/right PWM plus direction lines for the H-bridge. The `end_reset` line is the emergency halt; it bypasses debounce and forces both motors off.

## Interface
- `PWM_PERIOD`, 1000: PWM period in clock cycles; duty range 0..PWM_PERIOD.
- `DEBOUNCE_CYCLES`, 100000: consecutive stable cycles required before a new command word is accepted.
- `RAMP_DIV`, 1000: cycles between ramp steps.
- `RAMP_STEP`, 10: duty change per ramp step.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `state` input 8: raw command word. [1:0] dir (00 stop, 01 fwd, 10 rev, 11 spin); [3:2] turn (00 straight, 01 left, 10 right, 11 treated as straight); [6:4] speed 0..7; [7] ignored.
- `end_reset` input 1: emergency halt request, asynchronous to `clk`.
- `PWM_L`, `PWM_R` output 1: motor PWM.
- `DIR_L`, `DIR_R` output 1: 1 = forward.
- `mode` output 2: 00 IDLE, 01 RUN, 10 BRAKE, 11 HALT.
- `moving` output 1: high when either current duty is nonzero.

## Operation
- Input path:
  - `state` and `end_reset` each pass through a 2-flop synchronizer.
  - Synchronized `state[6:0]` feeds a stability counter that resets on any change.
  - When the counter reaches DEBOUNCE_CYCLES, the word is latched into `cmd`.
- Targets:
  - `tgt = (speed*PWM_PERIOD)>>3`.
  - A left turn halves the left target (`tgt>>1`); a right turn halves the right target.
  - dir 00 gives targets of 0.
- Directions:
  - fwd: both 1.
  - rev: both 0.
  - spin: DIR_L=0, DIR_R=1, both at full `tgt`.
- Ramp:
  - Every RAMP_DIV cycles, each current duty moves toward its target by RAMP_STEP.
  - The step is clamped so it never overshoots the target.
- FSM:
  - IDLE → RUN: a `cmd` with nonzero target arrives.
  - RUN → BRAKE: `cmd` requests a different DIR pattern while any duty is nonzero. In BRAKE both targets are forced to 0.
  - BRAKE → RUN or IDLE: both duties reach 0. DIR outputs update to the new pattern in that cycle, and the FSM goes to RUN (nonzero target) or IDLE.
  - RUN → IDLE: both duties reach 0 with zero targets.
  - Any state → HALT: synchronized `end_reset`=1. HALT zeroes both duties immediately (no ramp).
  - HALT → IDLE: synchronized `end_reset`=0 and accepted `cmd` dir = 00. A nonzero pending command keeps HALT, so the rover never lurches on release.
  - If IDLE/RUN exit and halt entry coincide, HALT wins.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - Output high while counter < latched duty.
  - The latched duty loads at counter wrap, except in HALT, where it is cleared immediately.
  - Duty 0 gives constant low; duty PWM_PERIOD gives constant high.

## Timing
- Reset values:
  - PWM_L=PWM_R=0, DIR_L=DIR_R=1, mode=00, moving=0.
  - Counters and duties 0; `cmd`=0.
- `end_reset` assertion → PWM outputs low and mode=11 within 3 clk edges (2 sync + 1 register). This bound is independent of PWM phase.
- Command latency = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles to `cmd`. The ramp then proceeds in whole RAMP_DIV steps.
- A duty change becomes visible on PWM at the next counter wrap (≤ PWM_PERIOD cycles).
- DIR never changes while the corresponding latched duty is nonzero.
- Reset asserted mid-operation clears everything asynchronously; outputs hold reset values until `reset` deasserts.
- All outputs are registered.

## Test plan
All scenarios use PWM_PERIOD=16, DEBOUNCE_CYCLES=4, RAMP_DIV=2, RAMP_STEP=4.
- Reset pulse mid-RUN → all outputs at reset values within the same cycle; mode=00 after release.
- `state`=0x71 held → after 7 cycles, duty ramps 4,8,12,14 at 2-cycle steps; steady PWM high 14 of 16 cycles; DIR_L=DIR_R=1; mode=01.
- `state` toggling 0x71/0x00 every 3 cycles → `cmd` never updates; PWM stays 0; mode=00.
- 0x71 steady, then 0x72 → mode=10; duty ramps 14→10→6→2→0 with DIR=1; DIR flips to 0 only at duty 0; ramps back to 14 in RUN.
- `end_reset`=1 mid-ramp → PWM low and mode=11 within 3 cycles. Release with `state`=0x71 → stays 11. Set 0x00, debounce, release → mode=00.
- 0x75 (left, speed 7) → left duty 7, right duty 14; 0x7B (spin) → DIR_L=0, DIR_R=1 after brake-to-zero.
